// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl
//   Command sequencer between the ARM handshake ports and the Montgomery /
//   exponentiation core. Decodes ARM commands, routes input words into one of
//   six operand slots, launches the core, captures its result and returns it
//   on a WRITE command. Every command ends with the done/done_read handshake.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   arm_to_fpga_cmd[_valid]   command code and strobe (sampled only in IDLE)
//   fpga_to_arm_done[_read]   command-complete flag and its acknowledge
//   arm_to_fpga_data*         input word valid/ready/data
//   fpga_to_arm_data*         result word valid/ready/data
//   op_wr_en, op_wr_data      one-hot slot write strobe and registered word
//   core_start, core_mode     core launch pulse and mode (1 = exponentiation)
//   core_done, core_result    core completion pulse and result
//   cycle_count               WAIT cycles spent by the last compute
//   leds                      {err, state[2:0]}
module rsa_cmd_ctrl #(
    parameter int unsigned DATA_W = 1024,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic [5:0]        op_wr_en,
    output logic [DATA_W-1:0] op_wr_data,
    output logic              core_start,
    output logic              core_mode,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [3:0]        leds
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX    = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        TX    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state, state_next;
    state_t              dec_next;
    logic [5:0]          dec_slot;
    logic                dec_mode;
    logic                dec_err;
    logic [5:0]          slot;
    logic                err;
    logic [DATA_W-1:0]   result;

    // Command decode, only consumed while IDLE.
    always_comb begin
        dec_next = DONE;
        dec_slot = '0;
        dec_mode = 1'b0;
        dec_err  = 1'b0;
        case (arm_to_fpga_cmd)
            32'd0:   begin dec_next = RX;    dec_slot = 6'b000001; end
            32'd1:   begin dec_next = RX;    dec_slot = 6'b000010; end
            32'd2:   begin dec_next = RX;    dec_slot = 6'b000100; end
            32'd5:   begin dec_next = RX;    dec_slot = 6'b001000; end
            32'd6:   begin dec_next = RX;    dec_slot = 6'b010000; end
            32'd7:   begin dec_next = RX;    dec_slot = 6'b100000; end
            32'd3:   begin dec_next = START; dec_mode = 1'b1;      end
            32'd4:   begin dec_next = START; dec_mode = 1'b0;      end
            32'd8:   begin dec_next = TX;                          end
            default: begin dec_next = DONE;  dec_err  = 1'b1;      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm_to_fpga_cmd_valid)  state_next = dec_next;
            RX:      if (arm_to_fpga_data_valid) state_next = DONE;
            START:   state_next = WAIT;
            WAIT:    if (core_done)              state_next = DONE;
            TX:      if (fpga_to_arm_data_ready) state_next = DONE;
            DONE:    if (fpga_to_arm_done_read)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore handshake outputs decode straight from the state register.
    assign arm_to_fpga_data_ready = (state == RX);
    assign fpga_to_arm_data_valid = (state == TX);
    assign fpga_to_arm_done       = (state == DONE);
    assign core_start             = (state == START);
    assign fpga_to_arm_data       = result;
    assign leds                   = {err, state};

    always_ff @(posedge clk) begin
        if (rst) begin
            slot        <= '0;
            err         <= 1'b0;
            core_mode   <= 1'b0;
            op_wr_en    <= '0;
            op_wr_data  <= '0;
            cycle_count <= '0;
            result      <= '0;
        end else begin
            op_wr_en <= '0;
            if (state == IDLE && arm_to_fpga_cmd_valid) begin
                err  <= dec_err;
                slot <= dec_slot;
                if (dec_next == START) core_mode <= dec_mode;
            end
            if (state == RX && arm_to_fpga_data_valid) begin
                op_wr_en   <= slot;
                op_wr_data <= arm_to_fpga_data;
            end
            if (state == START) cycle_count <= '0;
            if (state == WAIT) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                if (core_done) result <= core_result;
            end
        end
    end

endmodule

// File: doc/rsa_cmd_ctrl.md
# rsa_cmd_ctrl

Command sequencer between the ARM-facing command/data handshake ports and the Montgomery/exponentiation core datapath of the RSA accelerator. It decodes the 32-bit ARM commands and routes each 1024-bit input word into one of six operand slots. It starts the core in Montgomery-multiply or exponentiation mode, captures the result, and returns it on a write command. Every command closes with the done/done_read handshake.

## Interface
- DATA_W, 1024, operand/result width
- CNT_W, 32, compute-cycle counter width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- arm_to_fpga_cmd  in  32  command code, sampled with cmd_valid
- arm_to_fpga_cmd_valid  in  1  command strobe
- fpga_to_arm_done  out  1  command finished, held until done_read
- fpga_to_arm_done_read  in  1  ARM acknowledges done
- arm_to_fpga_data_valid  in  1  input word valid
- arm_to_fpga_data_ready  out  1  controller accepts input word
- arm_to_fpga_data  in  DATA_W  input word
- fpga_to_arm_data_valid  out  1  result word valid
- fpga_to_arm_data_ready  in  1  ARM accepts result
- fpga_to_arm_data  out  DATA_W  result word (result register)
- op_wr_en  out  6  one-hot operand slot write strobe, 1 cycle
- op_wr_data  out  DATA_W  registered copy of accepted input word
- core_start  out  1  core start pulse, 1 cycle
- core_mode  out  1  0 = Montgomery multiply, 1 = exponentiation
- core_done  in  1  core finished pulse
- core_result  in  DATA_W  core result, valid with core_done
- cycle_count  out  CNT_W  cycles spent in WAIT for the last compute
- leds  out  4  {err, state[2:0]}

## Operation
- Command codes and slots:
  - 0 READ_EXP → slot 0
  - 1 READ_A_B_MONT → slot 1
  - 2 READ_M_MONT → slot 2
  - 5 READ_EXP_MOD_RMOD → slot 3
  - 6 READ_EXP_RSQ_EXP → slot 4
  - 7 READ_EXP_X → slot 5
  - 3 COMPUTE_EXP: mode 1
  - 4 COMPUTE_MONT: mode 0
  - 8 WRITE
- States and encoding: IDLE=0, RX=1, START=2, WAIT=3, TX=4, DONE=5.
- IDLE: on cmd_valid, latch the command and clear err.
  - Read cmds → RX.
  - Compute cmds → START; latch core_mode.
  - WRITE → TX.
  - Any other code → DONE with err=1.
- RX: data_ready=1. On valid&ready: op_wr_data ← data, op_wr_en ← one-hot(slot) for the next cycle only, → DONE.
- START: core_start=1, cycle_count ← 0, → WAIT.
- WAIT: cycle_count +1 per cycle, saturating at all-ones. On core_done: result ← core_result, → DONE.
- TX: data_valid=1, fpga_to_arm_data=result. On valid&ready → DONE.
- DONE: done=1. On done_read → IDLE.
- cmd_valid outside IDLE is ignored; it is neither queued nor errored.
- core_done outside WAIT is ignored.
- WRITE before any compute returns 0.
- err is sticky until the next accepted command.

## Timing
- Reset: state=IDLE, err=0, and all outputs 0: done, data_ready, data_valid, op_wr_en, op_wr_data, core_start, core_mode, cycle_count, result, leds.
- The FSM is Moore: ready/valid/done/core_start decode from the registered state.
- Command accepted at edge T → new state visible in cycle T+1:
  - RX: ready high from T+1.
  - START: core_start high for exactly cycle T+1.
  - TX: valid high from T+1.
- Data handshake at edge H: op_wr_en pulses in cycle H+1, and done is high from H+1.
- Compute: if core_done is sampled at edge D, result is updated and done is high from D+1. cycle_count equals the number of WAIT cycles, including the core_done cycle.
- TX handshake at edge H: data_valid drops and done rises at H+1.
- done_read at edge R: IDLE at R+1. The earliest next command acceptance is edge R+1.
- A command with valid in the same cycle as done_read is ignored.
- Reset mid-operation overrides everything: IDLE next cycle, no op_wr_en or core_start emitted, result cleared.

## Test plan
- Load operand: cmd 1, word 0x…18d → ready rises 1 cycle after cmd. One cycle after the handshake: op_wr_en=6'b000010, op_wr_data matches the word, done=1. done_read → leds=4'b0000.
- Load all six slots (cmds 0,1,2,5,6,7) → op_wr_en = 000001, 000010, 000100, 001000, 010000, 100000 respectively, each a single-cycle pulse.
- COMPUTE_MONT with a core model asserting core_done 5 cycles after core_start, result 0xABCD → one-cycle core_start, core_mode=0, cycle_count=5, done high. A subsequent WRITE returns 0xABCD.
- COMPUTE_EXP then WRITE with data_ready delayed 3 cycles → core_mode=1. data_valid is held for 3 cycles, then drops, and done rises the next cycle.
- Invalid cmd 0x9 → DONE next cycle, leds=4'b1101. A second cmd_valid pulse while in DONE is ignored. After done_read and then cmd 1, err clears.
- Reset asserted in WAIT → next cycle IDLE, all outputs 0. A later core_done has no effect, and WRITE returns 0.
